// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller for a single-hart CPU.
// Sources: one level-sensitive timer line and four rising-edge external lines.
// Registers: ENABLE (0xFFFF0010), PENDING (0xFFFF0014), CAUSE (0xFFFF0018).
// A three-state FSM (IDLE -> REQ -> ACTIVE) presents one request at a time
// with fixed priority timer > ext0 > ext1 > ext2 > ext3 and no nesting.
// Build option: define IRQ_SYNC_EN to put a 2-flop synchronizer on each
// ext_irq bit ahead of the edge detector (two extra cycles of latency).
// The FSM state is held in state_q for checkers to bind to.
//
// Handshake: irq_req is high exactly while the FSM is in REQ; irq_ack sampled
// high in REQ moves to ACTIVE on that edge; irq_done sampled high in ACTIVE
// returns to IDLE on that edge. irq_ack and irq_done outside those states
// have no effect.

module irq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        write_enable,
  output logic [31:0] read_data,
  input  logic        timer_irq,
  input  logic [3:0]  ext_irq,
  input  logic        irq_ack,
  input  logic        irq_done,
  output logic        irq_req,
  output logic [4:0]  irq_cause
);

  localparam logic [31:0] ADDR_ENABLE  = 32'hFFFF_0010;
  localparam logic [31:0] ADDR_PENDING = 32'hFFFF_0014;
  localparam logic [31:0] ADDR_CAUSE   = 32'hFFFF_0018;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  localparam logic [4:0] CAUSE_TIMER = 5'd7;
  localparam logic [4:0] CAUSE_EXT0  = 5'd16;
  localparam logic [4:0] CAUSE_EXT1  = 5'd17;
  localparam logic [4:0] CAUSE_EXT2  = 5'd18;
  localparam logic [4:0] CAUSE_EXT3  = 5'd19;

  // Registers
  logic [1:0] state_q, state_d;
  logic [4:0] cause_q, cause_d;
  logic [4:0] src_q,   src_d;      // one-hot copy of the latched source
  logic [4:1] pend_q,  pend_d;
  logic [4:0] en_src_q;
  logic       en_glb_q;
  logic [3:0] ext_prev_q;
  logic [1:0] arm_cnt_q;

  // Combinational helpers
  logic [3:0] ext_s;
  logic [3:0] ext_rise;
  logic       armed;
  logic [4:0] pend_all;
  logic [4:0] elig;
  logic [4:0] sel_oh;
  logic [4:0] sel_cause;
  logic [4:1] ack_clr;
  logic [4:1] w1c_mask;
  logic       wr_enable_reg;
  logic       wr_pending_reg;
  logic       unused_wd;

`ifdef IRQ_SYNC_EN
  // The history register only reflects the real line level once the
  // synchronizer has been refilled, so edges stay masked for three cycles.
  localparam logic [1:0] ARM_CYCLES = 2'd3;
  logic [3:0] sync1_q, sync2_q;

  // Two-flop synchronizer on each external line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 4'b0;
      sync2_q <= 4'b0;
    end else begin
      sync1_q <= ext_irq;
      sync2_q <= sync1_q;
    end
  end

  assign ext_s = sync2_q;
`else
  // One cycle is enough for the history to pick up the line level.
  localparam logic [1:0] ARM_CYCLES = 2'd1;
  assign ext_s = ext_irq;
`endif

  // Lines already high when reset releases must not look like an edge:
  // the history loads for ARM_CYCLES cycles before edges are honoured.
  assign armed    = (arm_cnt_q == ARM_CYCLES);
  assign ext_rise = ext_s & ~ext_prev_q & {4{armed}};

  // Edge-detect history and post-reset arming counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_prev_q <= 4'b0;
      arm_cnt_q  <= 2'd0;
    end else begin
      ext_prev_q <= ext_s;
      if (!armed) arm_cnt_q <= arm_cnt_q + 2'd1;
    end
  end

  assign wr_enable_reg  = write_enable && (address == ADDR_ENABLE);
  assign wr_pending_reg = write_enable && (address == ADDR_PENDING);
  assign w1c_mask       = wr_pending_reg ? write_data[4:1] : 4'b0;
  assign unused_wd      = ^write_data[30:5];

  // PENDING[0] is the live timer level, never stored.
  assign pend_all = {pend_q, timer_irq};
  assign elig     = pend_all & en_src_q & {5{en_glb_q}};

  // Fixed-priority select of the highest eligible source
  always_comb begin
    sel_oh    = 5'b0;
    sel_cause = 5'd0;
    if (elig[0]) begin
      sel_oh = 5'b00001; sel_cause = CAUSE_TIMER;
    end else if (elig[1]) begin
      sel_oh = 5'b00010; sel_cause = CAUSE_EXT0;
    end else if (elig[2]) begin
      sel_oh = 5'b00100; sel_cause = CAUSE_EXT1;
    end else if (elig[3]) begin
      sel_oh = 5'b01000; sel_cause = CAUSE_EXT2;
    end else if (elig[4]) begin
      sel_oh = 5'b10000; sel_cause = CAUSE_EXT3;
    end
  end

  // Request FSM next state, cause latch and ack-clear of the served source
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    src_d   = src_q;
    ack_clr = 4'b0;
    case (state_q)
      ST_IDLE: begin
        if (|elig) begin
          state_d = ST_REQ;
          cause_d = sel_cause;
          src_d   = sel_oh;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          state_d = ST_ACTIVE;
          ack_clr = src_q[4:1];          // timer is a level, nothing to clear
        end else if (!(|(elig & src_q))) begin
          state_d = ST_IDLE;             // source went away: withdraw
        end
      end
      ST_ACTIVE: begin
        if (irq_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new edge wins over a software or ack clear in the same cycle.
  assign pend_d = (pend_q & ~w1c_mask & ~ack_clr) | ext_rise;

  // FSM, cause latch and pending flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cause_q <= 5'd0;
      src_q   <= 5'b0;
      pend_q  <= 4'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      src_q   <= src_d;
      pend_q  <= pend_d;
    end
  end

  // ENABLE register: per-source enables plus global enable in bit 31
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_src_q <= 5'b0;
      en_glb_q <= 1'b0;
    end else if (wr_enable_reg) begin
      en_src_q <= write_data[4:0];
      en_glb_q <= write_data[31];
    end
  end

  // CPU load path, purely combinational
  always_comb begin
    read_data = 32'h0;
    case (address)
      ADDR_ENABLE:  read_data = {en_glb_q, 26'b0, en_src_q};
      ADDR_PENDING: read_data = {27'b0, pend_all};
      ADDR_CAUSE:   read_data = {27'b0, cause_q};
      default:      read_data = 32'h0;
    endcase
  end

  assign irq_req   = (state_q == ST_REQ);
  assign irq_cause = cause_q;

endmodule
